// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_arb_pkg : shared states and defaults for ram_rr_arbiter       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package ram_arb_pkg;

   localparam int AW_DEF = 2;
   localparam int DW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RDATA = 2'b10
   } arb_state_e;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_rr_arbiter_if : requester-side bundle of the shared RAM port  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ram_rr_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) ();

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic               busy;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, busy
   );

endinterface : ram_rr_arbiter_if
`default_nettype wire

// File: rtl/ram_sp_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_sp_sync : single-port synchronous RAM, write or registered read|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module ram_sp_sync
   import ram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  wire logic          clk,
   input  wire logic          we,
   input  wire logic [AW-1:0] address,
   input  wire logic [DW-1:0] data_in,
   output logic      [DW-1:0] data_out
);

   logic [DW-1:0] mem [2**AW];

   // data_out holds its last value during writes
   always_ff @(posedge clk) begin
      if (we) begin
         mem[address] <= data_in;
      end else begin
         data_out <= mem[address];
      end
   end

endmodule : ram_sp_sync
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_rr_arbiter : round-robin sharing of one single-port RAM       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module ram_rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  wire logic         clk,
   input  wire logic         rst,
   ram_rr_arbiter_if.slave   bus
);

   localparam int IDW = (NREQ > 2) ? 2 : 1;

   arb_state_e     state_q,   state_d;
   logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
   logic [IDW-1:0] id_q,      id_d;
   logic           we_q,      we_d;
   logic [AW-1:0]  addr_q,    addr_d;
   logic [DW-1:0]  wdata_q,   wdata_d;

   logic [NREQ-1:0] gnt_w;
   logic [NREQ-1:0] rvalid_w;
   logic [DW-1:0]   rdata_w;
   logic            busy_w;
   logic            ram_we_w;
   logic [DW-1:0]   ram_dout;
   logic [IDW-1:0]  win_w;

   // First requester at or above ptr, wrapping around
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] pick;
      logic           found;
      int             j;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && r[j]) begin
            pick  = IDW'(j);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gnt_w    = '0;
      rvalid_w = '0;
      rdata_w  = '0;
      busy_w   = 1'b0;
      ram_we_w = 1'b0;
      win_w    = rr_pick(bus.req, rr_ptr_q);

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               id_d     = win_w;
               we_d     = bus.we[win_w];
               addr_d   = bus.addr[int'(win_w)*AW +: AW];
               wdata_d  = bus.wdata[int'(win_w)*DW +: DW];
               rr_ptr_d = (win_w == IDW'(NREQ-1)) ? '0 : win_w + 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            gnt_w    = NREQ'(1) << id_q;
            busy_w   = 1'b1;
            ram_we_w = we_q;
            state_d  = we_q ? IDLE : RDATA;
         end
         RDATA: begin
            rvalid_w = NREQ'(1) << id_q;
            rdata_w  = ram_dout;
            busy_w   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address/data stay on the latched command; only we decides commit
   ram_sp_sync #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk      (clk),
      .we       (ram_we_w),
      .address  (addr_q),
      .data_in  (wdata_q),
      .data_out (ram_dout)
   );

   assign bus.gnt    = gnt_w;
   assign bus.rvalid = rvalid_w;
   assign bus.rdata  = rdata_w;
   assign bus.busy   = busy_w;

endmodule : ram_rr_arbiter
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ram_rr_arbiter : directed self-checking bench, NREQ=2          |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_ram_rr_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ram_rr_arbiter_if #(.NREQ(2), .AW(2), .DW(4)) bus ();

   ram_rr_arbiter #(.NREQ(2), .AW(2), .DW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one command from IDLE; leaves the bench at the next IDLE negedge
   task automatic op(input int id, input bit w, input logic [1:0] a,
                     input logic [3:0] d, input string tag);
      bus.req              = '0;
      bus.req[id]          = 1'b1;
      bus.we[id]           = w;
      bus.addr[id*2 +: 2]  = a;
      bus.wdata[id*4 +: 4] = d;
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << id);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.req = '0;
      if (!w) begin
         chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'(1) << id);
         chk({tag, "_rdata"}, 32'(bus.rdata), 32'(d));
         @(negedge clk);
      end
      chk({tag, "_idle_gnt"}, 32'(bus.gnt), 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;

      #2;
      chk("rst_gnt",    32'(bus.gnt),       32'd0);
      chk("rst_rvalid", 32'(bus.rvalid),    32'd0);
      chk("rst_rdata",  32'(bus.rdata),     32'd0);
      chk("rst_busy",   32'(bus.busy),      32'd0);
      chk("rst_state",  32'(dut.state_q),   32'd0);
      chk("rst_ptr",    32'(dut.rr_ptr_q),  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // single write then read by requester 0
      op(0, 1'b1, 2'd2, 4'hA, "t1_wr");
      op(0, 1'b0, 2'd2, 4'hA, "t1_rd");
      chk("t1_rdata_idle", 32'(bus.rdata), 32'd0);
      chk("t1_ptr", 32'(dut.rr_ptr_q), 32'd1);

      // seed addr 1 with 5 via requester 1, leaving rr_ptr at 0
      op(1, 1'b1, 2'd1, 4'h5, "seed");
      chk("seed_ptr", 32'(dut.rr_ptr_q), 32'd0);

      // contention: both read addr 1
      bus.req  = 2'b11;
      bus.we   = 2'b00;
      bus.addr = {2'd1, 2'd1};
      @(negedge clk);
      chk("ct_gnt0", 32'(bus.gnt), 32'b01);
      @(negedge clk);
      bus.req = 2'b10;
      chk("ct_rv0",  32'(bus.rvalid), 32'b01);
      chk("ct_rd0",  32'(bus.rdata),  32'h5);
      @(negedge clk);
      chk("ct_idle", 32'(bus.gnt), 32'd0);
      @(negedge clk);
      chk("ct_gnt1", 32'(bus.gnt), 32'b10);
      @(negedge clk);
      bus.req = 2'b00;
      chk("ct_rv1",  32'(bus.rvalid), 32'b10);
      chk("ct_rd1",  32'(bus.rdata),  32'h5);
      @(negedge clk);
      chk("ct_ptr",  32'(dut.rr_ptr_q), 32'd0);

      // fairness: both write addr 0 continuously for 8 grants
      bus.req   = 2'b11;
      bus.we    = 2'b11;
      bus.addr  = {2'd0, 2'd0};
      bus.wdata = {4'h8, 4'h7};
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         chk($sformatf("fair_g%0d", g), 32'(bus.gnt), (g % 2 == 0) ? 32'b01 : 32'b10);
         @(negedge clk);
      end
      bus.req = 2'b00;
      @(negedge clk);

      // read-after-write across requesters
      op(1, 1'b1, 2'd3, 4'hC, "raw_wr");
      op(0, 1'b0, 2'd3, 4'hC, "raw_rd");

      // reset during RDATA
      bus.req        = 2'b01;
      bus.we         = 2'b00;
      bus.addr[1:0]  = 2'd2;
      @(negedge clk);
      chk("mr_gnt", 32'(bus.gnt), 32'b01);
      @(negedge clk);
      bus.req = 2'b00;
      chk("mr_rv_pre", 32'(bus.rvalid), 32'b01);
      #1 rst = 1'b1;
      #1;
      chk("mr_rvalid", 32'(bus.rvalid),  32'd0);
      chk("mr_gnt0",   32'(bus.gnt),     32'd0);
      chk("mr_busy",   32'(bus.busy),    32'd0);
      chk("mr_rdata",  32'(bus.rdata),   32'd0);
      chk("mr_state",  32'(dut.state_q), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("mr_ptr", 32'(dut.rr_ptr_q), 32'd0);
      op(1, 1'b0, 2'd1, 4'h5, "mr_after1");
      op(0, 1'b0, 2'd2, 4'hA, "mr_after0");

      // withdraw: req1 appears during req0's ISSUE and leaves before IDLE
      bus.req       = 2'b01;
      bus.we        = 2'b00;
      bus.addr      = {2'd0, 2'd1};
      @(negedge clk);
      chk("wd_gnt0", 32'(bus.gnt), 32'b01);
      bus.req[1]        = 1'b1;
      bus.we[1]         = 1'b1;
      bus.wdata[7:4]    = 4'hF;
      @(negedge clk);
      chk("wd_rv0", 32'(bus.rvalid), 32'b01);
      chk("wd_rd0", 32'(bus.rdata),  32'h5);
      bus.req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("wd_nognt", 32'(bus.gnt),     32'd0);
      chk("wd_busy",  32'(bus.busy),    32'd0);
      chk("wd_state", 32'(dut.state_q), 32'd0);
      op(0, 1'b0, 2'd0, 4'h8, "wd_ram");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ram_rr_arbiter
`default_nettype wire
